// File: rtl/multirate_v2_mac_sched.sv
// multirate_v2_mac_sched
//   Decimating FIR filter that time-shares one external 16s x 9s multiplier.
//   Every DECIM accepted samples it walks all NTAPS taps, one multiply-
//   accumulate per cycle, then presents the sum with a valid/ready handshake.
//
// Ports
//   ap_clk     : clock, rising edge
//   ap_rst_n   : asynchronous active-low reset
//   in_data    : signed input sample (16 b)
//   in_valid   : in_data valid
//   in_ready   : sample accepted this cycle (IDLE only)
//   coef_addr  : coefficient ROM address (tap index during MAC, else 0)
//   coef_data  : signed coefficient (9 b), combinational from coef_addr
//   mul_din0   : multiplier operand A, delay-line sample (0 outside MAC)
//   mul_din1   : multiplier operand B, coefficient (0 outside MAC)
//   mul_dout   : signed product from combinational multiplier (25 b)
//   out_data   : signed filter output (ACCW b)
//   out_valid  : out_data valid (OUT state)
//   out_ready  : downstream accepts out_data
//   busy       : high in MAC or OUT
module multirate_v2_mac_sched #(
   parameter int NTAPS = 8,
   parameter int DECIM = 2,
   parameter int ACCW  = 28,
   localparam int TW   = (NTAPS > 1) ? $clog2(NTAPS) : 1,
   localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic signed [15:0]     in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic        [TW-1:0]   coef_addr,
   input  logic signed [8:0]      coef_data,
   output logic signed [15:0]     mul_din0,
   output logic signed [8:0]      mul_din1,
   input  logic signed [24:0]     mul_dout,
   output logic signed [ACCW-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_t;

   state_t                 state;
   logic signed [15:0]     dl [NTAPS];
   logic signed [ACCW-1:0] acc;
   logic        [TW-1:0]   tap;
   logic        [PW-1:0]   phase;
   logic                   rdy_q;
   logic                   vld_q;
   logic                   busy_q;
   logic signed [ACCW-1:0] prod_ext;

   assign prod_ext = {{(ACCW-25){mul_dout[24]}}, mul_dout};

   // rdy_q tracks state==IDLE but stays low for the first cycle after reset,
   // so in_ready reads 0 while reset is held.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state  <= IDLE;
         for (int unsigned k = 0; k < NTAPS; k++) dl[k] <= '0;
         acc    <= '0;
         tap    <= '0;
         phase  <= '0;
         rdy_q  <= 1'b0;
         vld_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rdy_q <= 1'b1;
               if (in_valid && rdy_q) begin
                  dl[0] <= in_data;
                  for (int unsigned k = 1; k < NTAPS; k++) dl[k] <= dl[k-1];
                  if (phase == PW'(DECIM-1)) begin
                     phase  <= '0;
                     acc    <= '0;
                     tap    <= '0;
                     state  <= MAC;
                     rdy_q  <= 1'b0;
                     busy_q <= 1'b1;
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
            end
            MAC: begin
               acc <= acc + prod_ext;
               if (tap == TW'(NTAPS-1)) begin
                  state <= OUT;
                  vld_q <= 1'b1;
               end else begin
                  tap <= tap + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state  <= IDLE;
                  vld_q  <= 1'b0;
                  busy_q <= 1'b0;
                  rdy_q  <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               vld_q  <= 1'b0;
               busy_q <= 1'b0;
               rdy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      coef_addr = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      if (state == MAC) begin
         coef_addr = tap;
         mul_din0  = dl[tap];
         mul_din1  = coef_data;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_q;
   assign out_data  = acc;
   assign busy      = busy_q;

endmodule

// File: doc/multirate_v2_mac_sched.md
MULTIRATE_V2_MAC_SCHED -- requirements
Module: Multirate_v2_mac_sched

Interface
REQ-001 The block SHALL have parameter NTAPS, default 8, giving the FIR tap count (2..64).
REQ-002 The block SHALL have parameter DECIM, default 2, giving the decimation factor (1..16).
REQ-003 The block SHALL have parameter ACCW, default 28, giving the accumulator width (SHALL be >= 25 + clog2(NTAPS)).
REQ-004 Port ap_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_data, input, 16 bits: signed input sample.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 Port coef_addr, output, clog2(NTAPS) bits: coefficient ROM address.
REQ-010 Port coef_data, input, 9 bits: signed coefficient, combinationally valid in the same cycle as coef_addr.
REQ-011 Port mul_din0, output, 16 bits: operand A to the shared 16s x 9s multiplier.
REQ-012 Port mul_din1, output, 9 bits: operand B to the shared multiplier.
REQ-013 Port mul_dout, input, 25 bits: signed product; the multiplier is combinational (0-cycle).
REQ-014 Port out_data, output, ACCW bits: signed filter output.
REQ-015 Port out_valid, output, 1 bit: out_data is valid.
REQ-016 Port out_ready, input, 1 bit: the downstream accepts out_data.
REQ-017 Port busy, output, 1 bit: high while in state MAC or OUT.

Function
REQ-018 The block SHALL hold a delay line dl[0..NTAPS-1] of 16-bit samples; on an accepted input, dl[0] <= in_data and dl[k] <= dl[k-1].
REQ-019 The block SHALL implement the FSM states IDLE, MAC and OUT.
REQ-020 in_ready SHALL be 1 only in IDLE; an input is accepted when in_valid and in_ready are both 1.
REQ-021 IDLE transitions: on accept with phase==DECIM-1 -> phase<=0, acc<=0, tap<=0, state MAC; on accept otherwise -> phase<=phase+1, remain in IDLE; no accept -> hold.
REQ-022 MAC SHALL run exactly NTAPS cycles, driving each cycle coef_addr=tap, mul_din0=dl[tap], mul_din1=coef_data, and updating acc <= acc + sign-extend(mul_dout) and tap <= tap+1.
REQ-023 At tap==NTAPS-1, MAC SHALL perform the final accumulate and transition to OUT.
REQ-024 In OUT, out_valid SHALL be 1 and out_data SHALL equal acc, stable until the handshake completes; on out_ready==1 the FSM SHALL go to IDLE.
REQ-025 Outside MAC, mul_din0, mul_din1 and coef_addr SHALL be driven to 0.
REQ-026 Accumulation SHALL be two's-complement, wrapping at ACCW bits; with REQ-003 satisfied no overflow occurs.
REQ-027 Latency SHALL be: decimating accept in cycle T gives out_valid=1 in cycle T+NTAPS+1 (with out_ready held 1).
REQ-028 Throughput SHALL be one output per DECIM accepted inputs; the minimum period is NTAPS+2 cycles per output when DECIM==1.
REQ-029 Inputs SHALL NOT be accepted during MAC or OUT; upstream stalls (backpressure) and no samples are lost or duplicated.
REQ-030 With out_ready held 0, the block SHALL remain in OUT indefinitely with all state frozen.

Reset
REQ-031 With ap_rst_n==0, the block SHALL immediately set state=IDLE, dl[*]=0, acc=0, tap=0 and phase=0.
REQ-032 During reset, outputs SHALL be: in_ready=0, out_valid=0, out_data=0, busy=0, mul_din0/mul_din1/coef_addr=0.
REQ-033 in_ready SHALL rise in the first cycle after reset is released.
REQ-034 Asserting reset mid-MAC or in OUT SHALL abort the computation and discard any partial result; no out_valid is produced for it.

Verification
REQ-035 Impulse test (NTAPS=8, DECIM=1, coefficients c[k]=k+1): input 1 then seven 0s -> outputs 1,2,3,4,5,6,7,8.
REQ-036 Extreme-value test (NTAPS=8, DECIM=1): all samples -32768 and all coefficients -256 -> out_data=67108864 with no wrap.
REQ-037 Decimation test (DECIM=2, c[*]=1): inputs 1,2,3,4 -> exactly 2 outputs, equal to 3 and 10; in_ready remains 1 after the odd-numbered inputs.
REQ-038 Backpressure test: out_ready=0 for 20 cycles -> out_valid and out_data held stable and in_ready=0 throughout; the output is delivered once out_ready=1.
REQ-039 Reset test: ap_rst_n pulsed low at MAC tap 3 -> no out_valid is produced; a subsequent impulse yields the response of a zeroed delay line.
REQ-040 Latency check: a decimating accept at cycle T -> out_valid first high at cycle T+NTAPS+1.
